result_packetizer: RTL and testbench
====================================

// Module: result_packetizer
// PURPOSE
//  Downstream of the AFE sample/result buffer. Captures each new LED1/LED2 sample set
//  (new_samples pulse) and each SpO2/HR result (final_comp_complete pulse).
//  Frames them into fixed-length byte packets on a valid/ready byte stream for the UART tx.
//  Decouples bursty pulse-driven producers from a slow serial consumer using one-deep
//  holding registers per packet type, plus overrun counting.
// PARAMETERS
//  HEADER      8'hA5  first byte of every packet
//  DROP_CNT_W  8      width of the saturating overrun counter
// PORTS
//  clk                 in   1   system clock, all logic on rising edge
//  reset               in   1   synchronous, active-high reset
//  led_one             in   22  signed LED1 sample, valid when new_samples=1
//  led_two             in   22  signed LED2 sample, valid when new_samples=1
//  new_samples         in   1   1-cycle pulse: new sample set present
//  SPO2_in             in   24  SpO2 result, valid when final_comp_complete=1
//  HR_in               in   24  heart-rate result, valid when final_comp_complete=1
//  final_comp_complete in   1   1-cycle pulse: new result present
//  out_byte            out  8   stream byte
//  out_valid           out  1   out_byte is valid
//  in_ready            in   1   consumer accepts byte when out_valid & in_ready
//  busy                out  1   1 while a packet is in flight (state SEND)
//  drop_cnt            out  DROP_CNT_W  saturating count of overwritten, unsent captures
// BEHAVIOUR
//  Reset: out_byte=0, out_valid=0, busy=0, drop_cnt=0, both pending flags=0, state=IDLE.
//  Reset mid-packet aborts the packet. out_valid=0 from the next cycle. No resume.
//  Packet formats (9 bytes, MSB first, 24-bit fields):
//   sample: HEADER, 8'h01, sext24(led_one)[23:16..7:0], sext24(led_two)[23:16..7:0], CK
//   result: HEADER, 8'h02, SPO2[23:16..7:0], HR[23:16..7:0], CK
//   CK = XOR of bytes 1..7 (type byte and payload). HEADER is not included.
//   sext24 = {{2{x[21]}}, x}.
//  Capture: on the edge where a pulse is high, load its holding reg and set its pending flag.
//   If that pending flag is already set, the old value is overwritten (latest wins).
//   Each overwrite increments drop_cnt by 1 (saturating). Both pulses in one cycle
//   are captured independently.
//  FSM IDLE: if any pending, copy the chosen holding reg to the send snapshot, clear its
//   pending flag, set byte_idx=0, and go to SEND.
//   Result has priority over sample when both are pending.
//   If a capture pulse arrives in the same cycle that its flag is cleared, the new
//   value is latched and the pending flag stays set. That pulse is not a drop.
//  FSM SEND: out_valid=1 and out_byte=snapshot byte[byte_idx].
//   out_byte is held stable while out_valid & ~in_ready.
//   On handshake, byte_idx increments. On handshake with byte_idx=8, go to IDLE.
//   out_valid=0 in IDLE, so there is at least 1 idle cycle between packets.
//  Latency: a pulse sampled at edge E in IDLE with nothing pending gives out_valid=1
//   after edge E+2 (E+1 IDLE->SEND, E+2 first byte registered).
//  Captures during SEND never disturb the snapshot in flight.
//  CK is computed incrementally or combinationally from the snapshot. It is stable
//   before byte 8 is presented.
// TESTING
//  1. new_samples, led_one=22'h3FFFFF, led_two=22'h000123, in_ready=1 ->
//     A5 01 FF FF FF 00 01 23 CK=01^FF^FF^FF^00^01^23=DC. out_valid rises 2 cycles
//     after the pulse.
//  2. final_comp_complete, SPO2=24'h000062, HR=24'h00004B, in_ready=1 ->
//     A5 02 00 00 62 00 00 4B 2B.
//  3. Both pulses in the same cycle -> result packet first, then the sample packet.
//     drop_cnt=0.
//  4. in_ready=0 for 5 cycles mid-packet -> out_byte/out_valid held constant.
//     Byte count is still 9 and no byte is duplicated.
//  5. Three new_samples pulses during one in-flight packet -> the next sample packet
//     carries the third value. drop_cnt=2.
//  6. reset asserted at byte 4 -> out_valid=0 next cycle and all outputs at reset
//     values. A new pulse afterwards produces a full packet from byte 0.

Source files
------------

// File: rtl/result_packetizer_if.sv
// Bundle of the capture inputs and the byte-stream outputs of result_packetizer.
// The packetizer uses slave; the producer/consumer side uses master.
interface result_packetizer_if #(
  parameter int unsigned DROP_CNT_W = 8
);
  logic [21:0]           led_one;
  logic [21:0]           led_two;
  logic                  new_samples;
  logic [23:0]           spo2_in;
  logic [23:0]           hr_in;
  logic                  final_comp_complete;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic                  in_ready;
  logic                  busy;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output led_one, led_two, new_samples, spo2_in, hr_in, final_comp_complete, in_ready,
    input  out_byte, out_valid, busy, drop_cnt
  );

  modport slave (
    input  led_one, led_two, new_samples, spo2_in, hr_in, final_comp_complete, in_ready,
    output out_byte, out_valid, busy, drop_cnt
  );
endinterface

// File: rtl/result_packetizer.sv
// Frames LED sample sets and SpO2/HR results into 9-byte packets on a valid/ready byte
// stream, with one-deep latest-wins holding registers and a saturating overrun counter.
module result_packetizer #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  result_packetizer_if.slave bus
);
  localparam int unsigned PAYLOAD_W = 48;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_SUM_W = DROP_CNT_W + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(8);
  localparam logic [7:0]            TYPE_SAMP = 8'h01;
  localparam logic [7:0]            TYPE_RES  = 8'h02;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state;
  logic [PAYLOAD_W-1:0]  r_samp_hold;
  logic [PAYLOAD_W-1:0]  r_res_hold;
  logic                  r_samp_pend;
  logic                  r_res_pend;
  logic [PAYLOAD_W-1:0]  r_snap;
  logic [7:0]            r_type;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_out_byte;
  logic                  r_out_valid;
  logic                  r_busy;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [PAYLOAD_W-1:0]  w_samp_cap;
  logic [PAYLOAD_W-1:0]  w_res_cap;
  logic                  w_take_res;
  logic                  w_take_samp;
  logic                  w_samp_drop;
  logic                  w_res_drop;
  logic [CNT_SUM_W-1:0]  w_drop_sum;
  logic [DROP_CNT_W-1:0] w_drop_nxt;
  logic [7:0]            w_ck;
  logic [7:0]            w_cur_byte;
  logic [7:0]            w_next_byte;

  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0]     idx,
                                         input logic [PAYLOAD_W-1:0] snap,
                                         input logic [7:0]           typ,
                                         input logic [7:0]           ck);
    logic [7:0] b;
    case (idx)
      IDX_W'(0): b = HEADER;
      IDX_W'(1): b = typ;
      IDX_W'(2): b = snap[47:40];
      IDX_W'(3): b = snap[39:32];
      IDX_W'(4): b = snap[31:24];
      IDX_W'(5): b = snap[23:16];
      IDX_W'(6): b = snap[15:8];
      IDX_W'(7): b = snap[7:0];
      IDX_W'(8): b = ck;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  // Capture payloads and the IDLE-side hand-off of a pending holding register.
  always_comb begin
    w_samp_cap  = {{2{bus.led_one[21]}}, bus.led_one, {2{bus.led_two[21]}}, bus.led_two};
    w_res_cap   = {bus.spo2_in, bus.hr_in};
    w_take_res  = (r_state == S_IDLE) && r_res_pend;
    w_take_samp = (r_state == S_IDLE) && !r_res_pend && r_samp_pend;
    w_samp_drop = bus.new_samples && r_samp_pend && !w_take_samp;
    w_res_drop  = bus.final_comp_complete && r_res_pend && !w_take_res;
  end

  // Two simultaneous overwrites can add 2; the extra sum bit flags saturation.
  always_comb begin
    w_drop_sum = CNT_SUM_W'(r_drop_cnt) + CNT_SUM_W'(w_samp_drop) + CNT_SUM_W'(w_res_drop);
    w_drop_nxt = w_drop_sum[DROP_CNT_W] ? DROP_MAX : w_drop_sum[DROP_CNT_W-1:0];
  end

  always_comb begin
    w_ck        = r_type ^ r_snap[47:40] ^ r_snap[39:32] ^ r_snap[31:24]
                ^ r_snap[23:16] ^ r_snap[15:8] ^ r_snap[7:0];
    w_cur_byte  = byte_at(r_idx, r_snap, r_type, w_ck);
    w_next_byte = byte_at(r_idx + IDX_W'(1), r_snap, r_type, w_ck);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_samp_hold <= '0;
      r_res_hold  <= '0;
      r_samp_pend <= 1'b0;
      r_res_pend  <= 1'b0;
      r_snap      <= '0;
      r_type      <= 8'h00;
      r_idx       <= '0;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (bus.new_samples) begin
        r_samp_hold <= w_samp_cap;
        r_samp_pend <= 1'b1;
      end else if (w_take_samp) begin
        r_samp_pend <= 1'b0;
      end

      if (bus.final_comp_complete) begin
        r_res_hold <= w_res_cap;
        r_res_pend <= 1'b1;
      end else if (w_take_res) begin
        r_res_pend <= 1'b0;
      end

      r_drop_cnt <= w_drop_nxt;

      // First SEND cycle only registers byte 0; later cycles advance on handshake.
      case (r_state)
        S_IDLE: begin
          if (r_res_pend || r_samp_pend) begin
            r_state <= S_SEND;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_snap  <= r_res_pend ? r_res_hold : r_samp_hold;
            r_type  <= r_res_pend ? TYPE_RES : TYPE_SAMP;
          end
        end
        S_SEND: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_byte  <= w_cur_byte;
          end else if (bus.in_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_byte  <= 8'h00;
              r_idx       <= '0;
            end else begin
              r_idx      <= r_idx + IDX_W'(1);
              r_out_byte <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_byte  = r_out_byte;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_result_packetizer.sv
// Directed bench for result_packetizer: packet framing, priority, back-pressure,
// overrun counting/saturation and mid-packet reset.
module tb_result_packetizer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  result_packetizer_if #(.DROP_CNT_W(8)) u_if ();

  result_packetizer #(.HEADER(8'hA5), .DROP_CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_samples(input logic [21:0] l1, input logic [21:0] l2);
    u_if.led_one     = l1;
    u_if.led_two     = l2;
    u_if.new_samples = 1'b1;
    tick();
    u_if.new_samples = 1'b0;
  endtask

  task automatic pulse_result(input logic [23:0] spo2, input logic [23:0] hr);
    u_if.spo2_in             = spo2;
    u_if.hr_in               = hr;
    u_if.final_comp_complete = 1'b1;
    tick();
    u_if.final_comp_complete = 1'b0;
  endtask

  // Collects one packet (bounded), optionally stalling in_ready before byte stall_at.
  task automatic get_packet(input string tag, input logic [71:0] exp,
                            input int stall_at, input int stall_len);
    logic [71:0] pkt;
    logic [7:0]  hb;
    int          n;
    bit          stalled;
    pkt     = '0;
    n       = 0;
    stalled = 1'b0;
    for (int c = 0; c < 60 && n < 9; c++) begin
      if (stall_len > 0 && n == stall_at && !stalled && u_if.out_valid) begin
        stalled     = 1'b1;
        hb          = u_if.out_byte;
        u_if.in_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check($sformatf("%s_stall_byte%0d", tag, s), 32'(u_if.out_byte), 32'(hb));
          check($sformatf("%s_stall_valid%0d", tag, s), 32'(u_if.out_valid), 32'd1);
        end
        u_if.in_ready = 1'b1;
      end
      if (u_if.out_valid && u_if.in_ready) begin
        pkt = {pkt[63:0], u_if.out_byte};
        n++;
      end
      tick();
    end
    check({tag, "_len"}, 32'(n), 32'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_b%0d", tag, i), 32'(pkt[71-8*i -: 8]), 32'(exp[71-8*i -: 8]));
  endtask

  localparam logic [71:0] PKT_T1   = 72'hA5_01_FFFFFF_000123_DC;
  localparam logic [71:0] PKT_T2   = 72'hA5_02_000062_00004B_2B;
  localparam logic [71:0] PKT_RES3 = 72'hA5_02_123456_ABCDEF_FB;
  localparam logic [71:0] PKT_SMP3 = 72'hA5_01_000010_E00000_F1;
  localparam logic [71:0] PKT_T4   = 72'hA5_01_0ABCDE_154321_1E;
  localparam logic [71:0] PKT_T5   = 72'hA5_01_FFFFFE_000001_FE;

  initial begin
    reset                    = 1'b1;
    u_if.led_one             = '0;
    u_if.led_two             = '0;
    u_if.new_samples         = 1'b0;
    u_if.spo2_in             = '0;
    u_if.hr_in               = '0;
    u_if.final_comp_complete = 1'b0;
    u_if.in_ready            = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_out_byte", 32'(u_if.out_byte), 32'd0);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_drop_cnt", 32'(u_if.drop_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Sample packet with negative LED1 and its two-cycle latency.
    pulse_samples(22'h3FFFFF, 22'h000123);
    check("t1_lat_e0_valid", 32'(u_if.out_valid), 32'd0);
    tick();
    check("t1_lat_e1_valid", 32'(u_if.out_valid), 32'd0);
    check("t1_lat_e1_busy", 32'(u_if.busy), 32'd1);
    tick();
    check("t1_lat_e2_valid", 32'(u_if.out_valid), 32'd1);
    check("t1_lat_e2_byte", 32'(u_if.out_byte), 32'hA5);
    get_packet("t1", PKT_T1, 0, 0);
    check("t1_idle_after", 32'(u_if.out_valid), 32'd0);
    check("t1_busy_after", 32'(u_if.busy), 32'd0);

    // Result packet.
    pulse_result(24'h000062, 24'h00004B);
    get_packet("t2", PKT_T2, 0, 0);

    // Both pulses together: result first, then sample, no drops.
    u_if.led_one             = 22'h000010;
    u_if.led_two             = 22'h200000;
    u_if.new_samples         = 1'b1;
    u_if.spo2_in             = 24'h123456;
    u_if.hr_in               = 24'hABCDEF;
    u_if.final_comp_complete = 1'b1;
    tick();
    u_if.new_samples         = 1'b0;
    u_if.final_comp_complete = 1'b0;
    get_packet("t3_res", PKT_RES3, 0, 0);
    get_packet("t3_smp", PKT_SMP3, 0, 0);
    check("t3_drop_cnt", 32'(u_if.drop_cnt), 32'd0);

    // Five-cycle back-pressure while byte 3 is presented.
    pulse_samples(22'h0ABCDE, 22'h154321);
    get_packet("t4", PKT_T4, 3, 5);
    tick();
    check("t4_no_extra_byte", 32'(u_if.out_valid), 32'd0);

    // Three sample captures during a stalled in-flight result packet.
    u_if.in_ready = 1'b0;
    pulse_result(24'h000062, 24'h00004B);
    tick();
    tick();
    pulse_samples(22'h000001, 22'h000002);
    pulse_samples(22'h000003, 22'h000004);
    pulse_samples(22'h3FFFFE, 22'h000001);
    check("t5_drop_cnt", 32'(u_if.drop_cnt), 32'd2);
    check("t5_busy", 32'(u_if.busy), 32'd1);
    check("t5_held_byte", 32'(u_if.out_byte), 32'hA5);
    u_if.in_ready = 1'b1;
    get_packet("t5_res", PKT_T2, 0, 0);
    get_packet("t5_smp", PKT_T5, 0, 0);
    check("t5_drop_cnt_end", 32'(u_if.drop_cnt), 32'd2);

    // Overrun counter saturates while a sample packet is stalled.
    u_if.in_ready = 1'b0;
    pulse_samples(22'h000010, 22'h200000);
    tick();
    tick();
    u_if.final_comp_complete = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    u_if.final_comp_complete = 1'b0;
    check("sat_drop_cnt", 32'(u_if.drop_cnt), 32'd255);

    // Reset while byte 4 is presented aborts the packet and clears pending work.
    u_if.in_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t6_pre_byte4", 32'(u_if.out_byte), 32'h10);
    check("t6_pre_valid", 32'(u_if.out_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 32'(u_if.out_valid), 32'd0);
    check("t6_rst_byte", 32'(u_if.out_byte), 32'd0);
    check("t6_rst_busy", 32'(u_if.busy), 32'd0);
    check("t6_rst_drop", 32'(u_if.drop_cnt), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t6_no_resume", 32'(u_if.out_valid), 32'd0);
    pulse_result(24'h000062, 24'h00004B);
    get_packet("t6_new", PKT_T2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
